// File: rtl/act_quant_packer.sv
// Requantizes int16 MAC results to int8 (optional ReLU, round-half-up shift, saturate)
// and packs four lanes per 32-bit word, with a saturation event counter.
module act_quant_packer #(
    parameter int SHIFT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    input  logic        cfg_relu_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        out_last,
    output logic [15:0] sat_cnt
);

    // Half an LSB of the shifted result; zero when SHIFT is 0.
    localparam logic signed [16:0] RND = 17'((1 << SHIFT) >> 1);

    logic [1:0]         r_lane_cnt;
    logic [23:0]        r_pack;
    logic               r_out_valid;
    logic [31:0]        r_out_data;
    logic [2:0]         r_out_bytes;
    logic               r_out_last;
    logic [15:0]        r_sat_cnt;

    logic signed [16:0] w_x;
    logic signed [16:0] w_r;
    logic signed [16:0] w_q;
    logic               w_sat_hi;
    logic               w_sat_lo;
    logic               w_sat;
    logic [7:0]         w_byte;
    logic               w_accept;
    logic               w_emit;
    logic [31:0]        w_word;
    logic [23:0]        w_pack_next;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_emit   = w_accept && ((r_lane_cnt == 2'd3) || in_last);

    always_comb begin
        w_x = {in_data[15], in_data};
        if (cfg_relu_en && in_data[15]) begin
            w_x = '0;
        end
        w_r      = w_x + RND;
        w_q      = w_r >>> SHIFT;
        w_sat_hi = w_q > 17'sd127;
        w_sat_lo = w_q < -17'sd128;
        w_sat    = w_sat_hi || w_sat_lo;
        if (w_sat_hi) begin
            w_byte = 8'h7F;
        end else if (w_sat_lo) begin
            w_byte = 8'h80;
        end else begin
            w_byte = w_q[7:0];
        end
    end

    // Lanes above lane_cnt in r_pack are always zero, so the word needs no masking.
    always_comb begin
        w_word      = {8'h00, r_pack};
        w_pack_next = r_pack;
        case (r_lane_cnt)
            2'd0: begin
                w_word[7:0]       = w_byte;
                w_pack_next[7:0]  = w_byte;
            end
            2'd1: begin
                w_word[15:8]      = w_byte;
                w_pack_next[15:8] = w_byte;
            end
            2'd2: begin
                w_word[23:16]      = w_byte;
                w_pack_next[23:16] = w_byte;
            end
            default: begin
                w_word[31:24] = w_byte;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane_cnt  <= '0;
            r_pack      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_bytes <= '0;
            r_out_last  <= 1'b0;
            r_sat_cnt   <= '0;
        end else begin
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_word;
                r_out_bytes <= {1'b0, r_lane_cnt} + 3'd1;
                r_out_last  <= in_last;
                r_lane_cnt  <= '0;
                r_pack      <= '0;
            end else begin
                if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (w_accept) begin
                    r_lane_cnt <= r_lane_cnt + 2'd1;
                    r_pack     <= w_pack_next;
                end
            end
            if (w_accept && w_sat && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_bytes = r_out_bytes;
    assign out_last  = r_out_last;
    assign sat_cnt   = r_sat_cnt;

endmodule
